// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StAck,
        StWaitIdle
    } ps2_state_e;

    // Common keyboard commands.
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Common keyboard responses.
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // Watchdog width: covers the 20 ms default at 100 MHz.
    localparam int unsigned WdogW = 21;

    // Serial order after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] ps2_frame(logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and filter state; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shift on device clock falls,
// ACK check and a single done/ack_err/timeout result per accepted byte.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       idx_q, idx_d;
    logic [InhW-1:0]  inh_q, inh_d;
    logic [WdogW-1:0] wdog_q, wdog_d;

    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic done_q, done_d;
    logic ack_err_q, ack_err_d;
    logic timeout_q, timeout_d;

    logic evt_done, evt_ack_err, evt_timeout;
    logic wdog_hit;

    logic clk_level, fall;
    logic dsync1_q, dsync2_q;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_i),
        .level_o(clk_level),
        .fall_o (fall)
    );

    // Data line only needs metastability protection; it is sampled on falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsync1_q <= 1'b1;
            dsync2_q <= 1'b1;
        end else begin
            dsync1_q <= ps2_data_i;
            dsync2_q <= dsync1_q;
        end
    end

    // State register and frame datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            inh_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            inh_q   <= inh_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state logic, counters and result events.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        inh_d       = inh_q;
        wdog_d      = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
        evt_done    = 1'b0;
        evt_ack_err = 1'b0;
        evt_timeout = 1'b0;
        wdog_hit    = (wdog_q >= WdogLast) && !fall;
        if (fall) begin
            wdog_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                idx_d  = '0;
                inh_d  = '0;
                wdog_d = '0;
                if (tx_valid) begin
                    state_d = StInhibit;
                    shift_d = ps2_frame(tx_data);
                end
            end
            StInhibit: begin
                // Held at zero so the watchdog starts fresh on RTS entry.
                wdog_d = '0;
                if (inh_q == InhLast) begin
                    state_d = StRts;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            StRts: begin
                // SHIFT continues the RTS watchdog window rather than restarting it.
                if (wdog_hit) begin
                    evt_timeout = 1'b1;
                    state_d     = StIdle;
                end else begin
                    idx_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 4'd9) begin
                        state_d = StAck;
                    end
                end else if (wdog_hit) begin
                    evt_timeout = 1'b1;
                    state_d     = StIdle;
                end
            end
            StAck: begin
                if (fall) begin
                    if (!dsync2_q) begin
                        state_d = StWaitIdle;
                    end else begin
                        evt_ack_err = 1'b1;
                        state_d     = StIdle;
                    end
                end else if (wdog_hit) begin
                    evt_timeout = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWaitIdle: begin
                if (clk_level && dsync2_q) begin
                    evt_done = 1'b1;
                    state_d  = StIdle;
                end else if (wdog_hit) begin
                    evt_timeout = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, derived from where the FSM is heading.
    always_comb begin
        clk_oe_d  = (state_d == StInhibit);
        data_oe_d = data_oe_q;
        done_d    = evt_done;
        ack_err_d = evt_ack_err;
        timeout_d = evt_timeout;
        if (state_d == StIdle) begin
            data_oe_d = 1'b0;
        end else if (state_d == StInhibit) begin
            // Start bit goes low in the final inhibit cycle.
            data_oe_d = (inh_d == InhLast);
        end else if (state_d == StRts) begin
            data_oe_d = 1'b1;
        end else if (state_q == StShift && fall) begin
            data_oe_d = ~shift_q[idx_q];
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;
    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned Inh = 40;
    localparam int unsigned Tmo = 1500;
    localparam int unsigned Flt = 8;
    localparam int          H   = 30;   // device half period in system cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
    logic       ps2_clk_pin, ps2_data_pin;

    // Open-drain wired-AND bus.
    assign ps2_clk_pin  = !(ps2_clk_oe || dev_clk_low || glitch_low);
    assign ps2_data_pin = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo),
        .FILTER_LEN    (Flt)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ps2_clk_i  (ps2_clk_pin),
        .ps2_data_i (ps2_data_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_done = 0, n_ack = 0, n_to = 0, n_multi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Result pulse monitor.
    always @(negedge clk) begin
        if (done === 1'b1) n_done <= n_done + 1;
        if (ack_err === 1'b1) n_ack <= n_ack + 1;
        if (timeout === 1'b1) n_to <= n_to + 1;
        if (int'(done) + int'(ack_err) + int'(timeout) > 1) n_multi <= n_multi + 1;
    end

    // Expected wire bits after the start bit, from the frame rules.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Counts cycles with clk_oe high; returns at the first negedge it is low.
    task automatic measure_inhibit(output int hi, output logic last_doe, output logic prev_doe);
        hi = 0;
        last_doe = 1'b0;
        prev_doe = 1'b0;
        while (ps2_clk_oe === 1'b1 && hi < int'(Inh) + 100) begin
            prev_doe = last_doe;
            last_doe = ps2_data_oe;
            hi++;
            @(negedge clk);
        end
    endtask

    // Device side: waits for RTS, clocks the frame, samples data before each rise.
    task automatic device_frame(input bit ack, input bit glitch, input int stop_after,
                                output logic [9:0] bits, output bit rts_ok);
        bits = '0;
        rts_ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) begin
                rts_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!rts_ok) return;
        if (glitch) begin
            repeat (25) @(negedge clk);
            glitch_low = 1'b1;
            repeat (3) @(negedge clk);
            glitch_low = 1'b0;
            repeat (12) @(negedge clk);
        end else begin
            repeat (40) @(negedge clk);
        end
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            bits[k-1] = ps2_data_pin;
            dev_clk_low = 1'b0;
            if (k == stop_after) return;
            if (glitch) begin
                repeat (10) @(negedge clk);
                glitch_low = 1'b1;
                repeat (3) @(negedge clk);
                glitch_low = 1'b0;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_outcome(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1 || ack_err === 1'b1 || timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit ack, input bit glitch,
                            output logic oe1, output int hi, output logic last_doe,
                            output logic prev_doe, output logic [9:0] bits,
                            output bit rts_ok, output bit seen);
        send_req(b);
        oe1 = ps2_clk_oe;
        measure_inhibit(hi, last_doe, prev_doe);
        device_frame(ack, glitch, 0, bits, rts_ok);
        wait_outcome(seen);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout} !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL reset_in: outputs %b, required 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout} !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL reset_out: outputs %b, required 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout});
        end
    endtask

    task automatic test_send();
        logic [7:0] b;
        logic       oe1, last_doe, prev_doe;
        int         hi, d0, a0, t0;
        logic [9:0] bits;
        bit         rts_ok, seen;
        for (int t = 0; t < 4; t++) begin
            b = (t == 0) ? CMD_SET_LEDS : 8'($urandom_range(0, 255));
            d0 = n_done; a0 = n_ack; t0 = n_to;
            do_frame(b, 1'b1, 1'b0, oe1, hi, last_doe, prev_doe, bits, rts_ok, seen);
            tests_run++;
            if (oe1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL send_accept_lat: clk_oe %b one cycle after accept, required 1", oe1);
            end
            tests_run++;
            if (hi != int'(Inh)) begin
                tests_failed++;
                $display("FAIL send_inhibit_len: %0d cycles, required %0d", hi, Inh);
            end
            tests_run++;
            if (last_doe !== 1'b1 || prev_doe !== 1'b0) begin
                tests_failed++;
                $display("FAIL send_start_bit: data_oe last/prev %b/%b, required 1/0",
                         last_doe, prev_doe);
            end
            tests_run++;
            if (!rts_ok || bits !== exp_frame(b)) begin
                tests_failed++;
                $display("FAIL send_bits: byte %h rts %0d bits %b, required %b",
                         b, rts_ok, bits, exp_frame(b));
            end
            if (t == 0) begin
                tests_run++;
                if (bits !== 10'b11_1110_1101) begin
                    tests_failed++;
                    $display("FAIL send_ed_wire: bits %b, required 1111101101", bits);
                end
            end
            tests_run++;
            if (!seen || n_done - d0 != 1 || n_ack != a0 || n_to != t0) begin
                tests_failed++;
                $display("FAIL send_result: done/ack_err/timeout %0d/%0d/%0d, required 1/0/0",
                         n_done - d0, n_ack - a0, n_to - t0);
            end
            tests_run++;
            if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL send_idle: ready/busy/clk_oe/data_oe %b, required 1000",
                         {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
            end
        end
    endtask

    task automatic test_nack();
        logic       oe1, last_doe, prev_doe;
        int         hi, d0, a0;
        logic [9:0] bits;
        bit         rts_ok, seen;
        d0 = n_done; a0 = n_ack;
        do_frame(CMD_SET_LEDS, 1'b0, 1'b0, oe1, hi, last_doe, prev_doe, bits, rts_ok, seen);
        tests_run++;
        if (n_ack - a0 != 1 || n_done != d0) begin
            tests_failed++;
            $display("FAIL nack_result: ack_err %0d done %0d, required 1 and 0",
                     n_ack - a0, n_done - d0);
        end
        tests_run++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            tests_failed++;
            $display("FAIL nack_release: ready/clk_oe/data_oe %b, required 100",
                     {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_timeout();
        logic last_doe, prev_doe, doe_rts;
        int   hi, c0, c1, t0, d0;
        bit   seen;
        t0 = n_to; d0 = n_done;
        send_req(CMD_ECHO);
        measure_inhibit(hi, last_doe, prev_doe);
        c0 = cyc;
        doe_rts = ps2_data_oe;
        seen = 1'b0;
        c1 = c0;
        for (int i = 0; i < int'(Tmo) + 200; i++) begin
            if (timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        c1 = cyc;
        tests_run++;
        if (doe_rts !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_rts_data: data_oe %b at RTS, required 1", doe_rts);
        end
        tests_run++;
        if (!seen || c1 - c0 != int'(Tmo)) begin
            tests_failed++;
            $display("FAIL timeout_latency: seen %0d after %0d cycles, required %0d",
                     seen, c1 - c0, Tmo);
        end
        tests_run++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            tests_failed++;
            $display("FAIL timeout_release: ready/clk_oe/data_oe %b, required 100",
                     {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (n_to - t0 != 1 || n_done != d0) begin
            tests_failed++;
            $display("FAIL timeout_count: timeout %0d done %0d, required 1 and 0",
                     n_to - t0, n_done - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic       oe1, last_doe, prev_doe, rdy, oe_next, busy_next;
        int         hi, d0;
        logic [9:0] bits, bits2;
        bit         rts_ok, rts_ok2, seen;
        logic [7:0] b2;
        b2 = 8'($urandom_range(0, 255));
        d0 = n_done;
        send_req(CMD_RESET);
        measure_inhibit(hi, last_doe, prev_doe);
        fork
            device_frame(1'b1, 1'b0, 0, bits, rts_ok);
            begin
                repeat (150) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (200) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        rdy = tx_ready;
        tx_data  = b2;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid  = 1'b0;
        oe_next   = ps2_clk_oe;
        busy_next = busy;
        tests_run++;
        if (!rts_ok || bits !== exp_frame(CMD_RESET)) begin
            tests_failed++;
            $display("FAIL b2b_ignore: bits %b, required %b", bits, exp_frame(CMD_RESET));
        end
        tests_run++;
        if (!seen || rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: done seen %0d ready %b, required 1 and 1", seen, rdy);
        end
        tests_run++;
        if (oe_next !== 1'b1 || busy_next !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: clk_oe %b busy %b, required 1 and 1", oe_next, busy_next);
        end
        measure_inhibit(hi, last_doe, prev_doe);
        device_frame(1'b1, 1'b0, 0, bits2, rts_ok2);
        wait_outcome(seen);
        tests_run++;
        if (!rts_ok2 || bits2 !== exp_frame(b2) || n_done - d0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_second: bits %b done %0d, required %b and 2",
                     bits2, n_done - d0, exp_frame(b2));
        end
    endtask

    task automatic test_reset_mid();
        logic       oe1, last_doe, prev_doe, doe_before;
        int         hi, d0;
        logic [9:0] bits;
        bit         rts_ok, seen;
        logic [7:0] b;
        send_req(CMD_SET_LEDS);
        measure_inhibit(hi, last_doe, prev_doe);
        device_frame(1'b1, 1'b0, 5, bits, rts_ok);
        doe_before = ps2_data_oe;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (doe_before !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_before: data_oe %b after fall 5, required 1", doe_before);
        end
        tests_run++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout} !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL rstmid_async: outputs %b, required 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        b = 8'($urandom_range(0, 255));
        d0 = n_done;
        do_frame(b, 1'b1, 1'b0, oe1, hi, last_doe, prev_doe, bits, rts_ok, seen);
        tests_run++;
        if (hi != int'(Inh) || bits !== exp_frame(b) || n_done - d0 != 1) begin
            tests_failed++;
            $display("FAIL rstmid_clean: inhibit %0d bits %b done %0d, required %0d %b 1",
                     hi, bits, n_done - d0, Inh, exp_frame(b));
        end
    endtask

    task automatic test_glitch();
        logic       oe1, last_doe, prev_doe;
        int         hi, d0, a0;
        logic [9:0] bits;
        bit         rts_ok, seen;
        logic [7:0] b;
        for (int t = 0; t < 2; t++) begin
            b = 8'($urandom_range(0, 255));
            d0 = n_done; a0 = n_ack;
            do_frame(b, 1'b1, 1'b1, oe1, hi, last_doe, prev_doe, bits, rts_ok, seen);
            tests_run++;
            if (!rts_ok || bits !== exp_frame(b)) begin
                tests_failed++;
                $display("FAIL glitch_bits: byte %h bits %b, required %b", b, bits, exp_frame(b));
            end
            tests_run++;
            if (n_done - d0 != 1 || n_ack != a0) begin
                tests_failed++;
                $display("FAIL glitch_result: done %0d ack_err %0d, required 1 and 0",
                         n_done - d0, n_ack - a0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_send();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        tests_run++;
        if (n_multi != 0) begin
            tests_failed++;
            $display("FAIL exclusive_pulses: %0d overlapping cycles, required 0", n_multi);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
